// File: rtl/shift_reg_univ_n.sv
// shift_reg_univ_n: parametrised universal shift register with an optional
// multi-step shift sequencer. Bit 0 is the MSB/sign bit.
//
// Ports:
//   clk     - clock, all state changes on posedge
//   reset   - asynchronous active-high reset, clears all state
//   op      - operation code (HOLD, LOAD, SH0, SHN, ROT0, ROTN, ASHN, CLEAR)
//   d       - parallel load data
//   sin_n   - serial in entering bit WIDTH-1 on shift toward bit 0
//   sin_0   - serial in entering bit 0 on shift toward bit WIDTH-1
//   start   - begin a multi-step sequence using op and count
//   count   - number of steps for the sequence
//   abort   - synchronous cancel of an active sequence
//   q       - register value
//   sout_0  - q[0], for cascading
//   sout_n  - q[WIDTH-1], for cascading
//   busy    - sequence in progress
//   done    - one-cycle pulse on sequence completion
module shift_reg_univ_n #(
  parameter int WIDTH = 36,
  parameter int CNTW  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        op,
  input  logic [0:WIDTH-1]  d,
  input  logic              sin_n,
  input  logic              sin_0,
  input  logic              start,
  input  logic [CNTW-1:0]   count,
  input  logic              abort,
  output logic [0:WIDTH-1]  q,
  output logic              sout_0,
  output logic              sout_n,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_LOAD  = 3'd1,
    OP_SH0   = 3'd2,
    OP_SHN   = 3'd3,
    OP_ROT0  = 3'd4,
    OP_ROTN  = 3'd5,
    OP_ASHN  = 3'd6,
    OP_CLEAR = 3'd7
  } op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          state, state_nx;
  op_t             op_lat, op_lat_nx;
  logic [0:WIDTH-1] d_lat, d_lat_nx;
  logic [CNTW-1:0] remaining, remaining_nx;
  logic [0:WIDTH-1] q_nx;
  logic            done_nx;

  function automatic logic [0:WIDTH-1] apply_op(
    input op_t              o,
    input logic [0:WIDTH-1] cur,
    input logic [0:WIDTH-1] ld,
    input logic             si_n,
    input logic             si_0
  );
    logic [0:WIDTH-1] r;
    r = cur;
    case (o)
      OP_HOLD:  r = cur;
      OP_LOAD:  r = ld;
      OP_SH0:   r = {cur[1:WIDTH-1], si_n};
      OP_SHN:   r = {si_0, cur[0:WIDTH-2]};
      OP_ROT0:  r = {cur[1:WIDTH-1], cur[0]};
      OP_ROTN:  r = {cur[WIDTH-1], cur[0:WIDTH-2]};
      OP_ASHN:  r = {cur[0], cur[0:WIDTH-2]};
      OP_CLEAR: r = '0;
      default:  r = cur;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      op_lat    <= OP_HOLD;
      d_lat     <= '0;
      remaining <= '0;
      q         <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      op_lat    <= op_lat_nx;
      d_lat     <= d_lat_nx;
      remaining <= remaining_nx;
      q         <= q_nx;
      done      <= done_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    op_lat_nx    = op_lat;
    d_lat_nx     = d_lat;
    remaining_nx = remaining;
    q_nx         = q;
    done_nx      = 1'b0;
    case (state)
      S_IDLE: begin
        // abort while idle suppresses start, so the op is applied instead.
        if (start && !abort) begin
          op_lat_nx = op_t'(op);
          // d is captured so a latched LOAD stays idempotent while d is ignored.
          d_lat_nx  = d;
          if (count != '0) begin
            state_nx     = S_RUN;
            remaining_nx = count;
          end else begin
            done_nx = 1'b1;
          end
        end else begin
          q_nx = apply_op(op_t'(op), q, d, sin_n, sin_0);
        end
      end
      S_RUN: begin
        // abort wins over the final step: no step applied, no done pulse.
        if (abort) begin
          state_nx     = S_IDLE;
          remaining_nx = '0;
        end else begin
          q_nx         = apply_op(op_lat, q, d_lat, sin_n, sin_0);
          remaining_nx = remaining - CNTW'(1);
          if (remaining == CNTW'(1)) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy   = (state == S_RUN);
  assign sout_0 = q[0];
  assign sout_n = q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_univ_n.sv
module tb_shift_reg_univ_n;

  localparam int W = 8;
  localparam int C = 6;

  logic         clk;
  logic         reset;
  logic [2:0]   op;
  logic [W-1:0] d;
  logic         sin_n, sin_0, start, abort;
  logic [C-1:0] count;
  logic [W-1:0] q;
  logic         sout_0, sout_n, busy, done;

  int n_assert = 0;
  int n_fail   = 0;

  // expected {q, sout_0, sout_n, busy, done}
  logic [W+3:0] exp_q[$];
  string        tag_q[$];

  shift_reg_univ_n #(.WIDTH(W), .CNTW(C)) dut (
    .clk(clk), .reset(reset), .op(op), .d(d), .sin_n(sin_n), .sin_0(sin_0),
    .start(start), .count(count), .abort(abort), .q(q), .sout_0(sout_0),
    .sout_n(sout_n), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_state(input string tag, input logic [W-1:0] eq,
                              input logic eb, input logic ed);
    // tb bit 7 is DUT bit 0 (MSB), so sout_0 follows eq[7] and sout_n eq[0]
    exp_q.push_back({eq, eq[W-1], eq[0], eb, ed});
    tag_q.push_back(tag);
  endtask

  task automatic check_pop();
    logic [W+3:0] e;
    logic [W+3:0] o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {q, sout_0, sout_n, busy, done};
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed q=%h s0/sn/busy/done=%b required q=%h s0/sn/busy/done=%b",
             t, o[W+3:4], o[3:0], e[W+3:4], e[3:0]);
    end
  endtask

  task automatic tick_check(input string tag, input logic [W-1:0] eq,
                            input logic eb, input logic ed);
    expect_state(tag, eq, eb, ed);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  task automatic load(input logic [W-1:0] v);
    op = 3'd1; d = v; start = 1'b0; abort = 1'b0;
    tick_check("load", v, 1'b0, 1'b0);
  endtask

  logic [2:0]   op_tab [8];
  logic [W-1:0] res_tab[8];

  initial begin
    reset = 1'b1; op = 3'd0; d = '0; sin_n = 1'b0; sin_0 = 1'b0;
    start = 1'b0; count = '0; abort = 1'b0;
    #12;
    reset = 1'b0;
    expect_state("reset_state", 8'h00, 1'b0, 1'b0);
    check_pop();

    // single ops from 1001_0110 with sin_n=1, sin_0=0
    op_tab  = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
    res_tab = '{8'h96, 8'h2D, 8'h4B, 8'h2D, 8'h4B, 8'hCB, 8'h00, 8'h3C};
    for (int i = 0; i < 8; i++) begin
      load(8'h96);
      op = op_tab[i]; d = 8'h3C; sin_n = 1'b1; sin_0 = 1'b0;
      tick_check($sformatf("single_op%0d", op_tab[i]), res_tab[i], 1'b0, 1'b0);
    end

    // ROT0 x3 from 81; op/d changes while busy must be ignored
    load(8'h81);
    op = 3'd4; start = 1'b1; count = 6'd3;
    tick_check("rot_start", 8'h81, 1'b1, 1'b0);
    start = 1'b0; op = 3'd1; d = 8'h00; count = 6'd9;
    tick_check("rot_step1", 8'h03, 1'b1, 1'b0);
    tick_check("rot_step2", 8'h06, 1'b1, 1'b0);
    tick_check("rot_step3", 8'h0C, 1'b0, 1'b1);
    op = 3'd0;
    tick_check("rot_after", 8'h0C, 1'b0, 1'b0);

    // ASHN x10 from 80, count above width
    load(8'h80);
    op = 3'd6; start = 1'b1; count = 6'd10;
    tick_check("ash_start", 8'h80, 1'b1, 1'b0);
    start = 1'b0; op = 3'd0;
    for (int i = 1; i <= 10; i++) begin
      logic signed [W-1:0] s;
      s = 8'sh80 >>> i;
      tick_check($sformatf("ash_step%0d", i), s, i < 10, i == 10);
    end
    tick_check("ash_after", 8'hFF, 1'b0, 1'b0);

    // zero-count start
    op = 3'd2; start = 1'b1; count = 6'd0;
    tick_check("zero_start", 8'hFF, 1'b0, 1'b1);
    start = 1'b0; op = 3'd0;
    tick_check("zero_after", 8'hFF, 1'b0, 1'b0);

    // abort on 2nd step of SH0 x5 from FF, then restart
    load(8'hFF);
    op = 3'd2; sin_n = 1'b0; start = 1'b1; count = 6'd5;
    tick_check("abort_start", 8'hFF, 1'b1, 1'b0);
    start = 1'b0; op = 3'd0;
    tick_check("abort_step1", 8'hFE, 1'b1, 1'b0);
    abort = 1'b1;
    tick_check("abort_edge", 8'hFE, 1'b0, 1'b0);
    abort = 1'b0; op = 3'd3; sin_0 = 1'b0; start = 1'b1; count = 6'd2;
    tick_check("restart_start", 8'hFE, 1'b1, 1'b0);
    start = 1'b0; op = 3'd0;
    tick_check("restart_step1", 8'h7F, 1'b1, 1'b0);
    tick_check("restart_step2", 8'h3F, 1'b0, 1'b1);

    // back-to-back start in the done cycle
    op = 3'd5; start = 1'b1; count = 6'd1;
    tick_check("b2b_start", 8'h3F, 1'b1, 1'b0);
    start = 1'b0; op = 3'd0;
    tick_check("b2b_step1", 8'h9F, 1'b0, 1'b1);

    // abort with start while idle: op applied, start ignored
    op = 3'd7; start = 1'b1; abort = 1'b1; count = 6'd3;
    tick_check("idle_abort_start", 8'h00, 1'b0, 1'b0);
    start = 1'b0; abort = 1'b0; op = 3'd0;
    tick_check("idle_abort_after", 8'h00, 1'b0, 1'b0);

    // async reset mid-sequence
    load(8'hA5);
    op = 3'd2; sin_n = 1'b1; start = 1'b1; count = 6'd5;
    tick_check("rst_seq_start", 8'hA5, 1'b1, 1'b0);
    start = 1'b0; op = 3'd0;
    #2;
    reset = 1'b1;
    #1;
    expect_state("async_reset", 8'h00, 1'b0, 1'b0);
    check_pop();
    reset = 1'b0;
    tick_check("post_reset_idle", 8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
